// File: rtl/ids_dma_ctrl_if.sv
// ids_dma_ctrl_if: DMEM bus between the DMA master and the arbitrated SRAM port.
interface ids_dma_ctrl_if;
  logic        o_req;
  logic        i_gnt;
  logic [31:0] o_addr;
  logic        o_read;
  logic        o_write;
  logic [3:0]  o_size;
  logic [31:0] o_din;
  logic [31:0] i_dout;
  modport master (output o_req, o_addr, o_read, o_write, o_size, o_din, input i_gnt, i_dout);
  modport slave  (input o_req, o_addr, o_read, o_write, o_size, o_din, output i_gnt, i_dout);
endinterface

// File: rtl/ids_dma_ctrl.sv
// ids_dma_ctrl: DMEM word-copy DMA master (read/write alternation under arbiter grant).
// IDS_DMA_FILL_EN adds a fill mode that writes a latched constant instead of copying.
module ids_dma_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
`ifdef IDS_DMA_FILL_EN
  input  logic             i_fill,
  input  logic [31:0]      i_fill_data,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_remaining,
  ids_dma_ctrl_if.master   io_mem
);
  typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, DONE} state_t;
  state_t           r_state;
  logic [31:0]      r_src, r_dst, r_buf, r_addr;
  logic [LEN_W-1:0] r_rem;
  logic             r_busy, r_done, r_req, r_read, r_write, r_fill;
  logic [LEN_W-1:0] w_rem_dec;
  logic [31:0]      w_src_inc, w_dst_inc;
  assign w_rem_dec = r_rem - LEN_W'(1);
  assign w_src_inc = r_src + 32'd4;
  assign w_dst_inc = r_dst + 32'd4;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_fill  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_src  <= i_src_addr;
          r_dst  <= i_dst_addr;
          r_rem  <= i_len;
          r_busy <= 1'b1;
`ifdef IDS_DMA_FILL_EN
          r_fill <= i_fill;
          if (i_fill) r_buf <= i_fill_data;
`else
          r_fill <= 1'b0;
`endif
          if (i_len == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
`ifdef IDS_DMA_FILL_EN
          else if (i_fill) begin
            r_state <= WR;
            r_req   <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= i_dst_addr;
          end
`endif
          else begin
            r_state <= RD;
            r_req   <= 1'b1;
            r_read  <= 1'b1;
            r_addr  <= i_src_addr;
          end
        end
        RD: if (i_abort) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_read  <= 1'b0;
        end else if (io_mem.i_gnt) begin
          r_state <= RD_DATA;
          r_req   <= 1'b0;
          r_read  <= 1'b0;
        end
        RD_DATA: begin
          // SRAM data is valid here whether or not the bus is still ours
          r_buf <= io_mem.i_dout;
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= WR;
            r_req   <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= r_dst;
          end
        end
        WR: begin
          if (io_mem.i_gnt) begin
            r_rem <= w_rem_dec;
            r_dst <= w_dst_inc;
            if (!r_fill) r_src <= w_src_inc;
          end
          // a granted write in the abort cycle still lands and is counted
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
            r_write <= 1'b0;
          end else if (io_mem.i_gnt) begin
            if (w_rem_dec == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_req   <= 1'b0;
              r_write <= 1'b0;
            end else if (r_fill) begin
              r_addr <= w_dst_inc;
            end else begin
              r_state <= RD;
              r_read  <= 1'b1;
              r_write <= 1'b0;
              r_addr  <= w_src_inc;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_remaining    = r_rem;
  assign io_mem.o_req   = r_req;
  assign io_mem.o_read  = r_read;
  assign io_mem.o_write = r_write;
  assign io_mem.o_addr  = r_addr;
  assign io_mem.o_din   = r_buf;
  assign io_mem.o_size  = 4'b1111;
endmodule

// File: tb/tb_ids_dma_ctrl.sv
// tb_ids_dma_ctrl: directed bench for ids_dma_ctrl with an SRAM model and a write scoreboard.
module tb_ids_dma_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0;
  logic        busy, done;
  logic [15:0] remaining;
`ifdef IDS_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] fill_data = '0;
`endif
  logic [31:0] mem [0:255];
  logic [63:0] exp_q [$];
  int          cyc = 0, t0 = 0, checks = 0, errors = 0, done_cnt = 0;
  logic        saw_req = 1'b0, saw_read = 1'b0;
  ids_dma_ctrl_if bus ();
  ids_dma_ctrl #(.LEN_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_src_addr(src), .i_dst_addr(dst),
    .i_len(len), .i_abort(abort),
`ifdef IDS_DMA_FILL_EN
    .i_fill(fill), .i_fill_data(fill_data),
`endif
    .o_busy(busy), .o_done(done), .o_remaining(remaining), .io_mem(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.o_read && bus.i_gnt) bus.i_dout <= mem[bus.o_addr[9:2]];
    if (bus.o_write && bus.i_gnt) mem[bus.o_addr[9:2]] <= bus.o_din;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (done) done_cnt++;
    if (bus.o_req) saw_req = 1'b1;
    if (bus.o_read) saw_read = 1'b1;
    if (bus.o_write && bus.i_gnt) begin
      if (exp_q.size() == 0) chk("wr_unexpected", {bus.o_addr, bus.o_din}, 64'h0);
      else chk("wr_data", {bus.o_addr, bus.o_din}, exp_q.pop_front());
    end
  end
  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      b = d + 32'(4 * i);
      exp_q.push_back({b, mem[a[9:2]]});
    end
  endtask
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; src = s; dst = d; len = l; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int dt);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    chk({tag, "_done_time"}, 64'(cyc - t0), 64'(dt));
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done, busy}, 2'b00);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask
  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    bus.i_gnt = 1'b1;
    #12;
    chk("rst_ctl", {busy, done, bus.o_req, bus.o_read, bus.o_write}, 5'b0);
    chk("rst_addr", bus.o_addr, 32'h0);
    chk("rst_din", bus.o_din, 32'h0);
    chk("rst_rem", remaining, 16'h0);
    chk("rst_size", bus.o_size, 4'hF);
    rst_n = 1'b1;
    // plain copy, continuous grant
    push_copy(32'h100, 32'h200, 4);
    start_xfer(32'h100, 32'h200, 16'd4);
    wait_done("copy", 13);
    chk("copy_rem", remaining, 16'h0);
    for (int i = 0; i < 4; i++) chk("copy_mem", mem[64 + i], mem[128 + i]);
    // five-cycle grant stall on the read of word 2
    push_copy(32'h140, 32'h240, 4);
    start_xfer(32'h140, 32'h240, 16'd4);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.o_read && bus.o_addr == 32'h144) && n < 50);
    chk("stall_seen", n < 50, 1'b1);
    bus.i_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {bus.o_req, bus.o_read, bus.o_write, bus.o_addr}, {3'b110, 32'h144});
    end
    bus.i_gnt = 1'b1;
    wait_done("stall", 18);
    // zero-length transfer
    @(negedge clk); saw_req = 1'b0;
    start_xfer(32'h100, 32'h200, 16'd0);
    wait_done("len0", 1);
    chk("len0_noreq", saw_req, 1'b0);
    // abort on the granted write of word 2
    push_copy(32'h180, 32'h280, 2);
    n = done_cnt;
    start_xfer(32'h180, 32'h280, 16'd3);
    do begin @(negedge clk); n++; end while (!(bus.o_write && bus.o_addr == 32'h284) && n < 100);
    n = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, bus.o_req, bus.o_write}, 3'b000);
    chk("abort_rem", remaining, 16'd1);
    chk("abort_mem", mem[161], mem[97]);
    repeat (3) @(negedge clk);
    chk("abort_nodone", done_cnt - n, 0);
    chk("abort_sb_empty", exp_q.size(), 0);
    // async reset while waiting for read data
    start_xfer(32'h100, 32'h2C0, 16'd4);
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !bus.o_req) && n < 50);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {busy, done, bus.o_req, bus.o_read, bus.o_write}, 5'b0);
    chk("arst_data", {bus.o_addr, bus.o_din}, 64'h0);
    chk("arst_rem", {remaining, bus.o_size}, {16'h0, 4'hF});
    rst_n = 1'b1;
    push_copy(32'h100, 32'h2C0, 2);
    start_xfer(32'h100, 32'h2C0, 16'd2);
    wait_done("arst_restart", 7);
    // address wrap, with a start pulse during the transfer that must be ignored
    push_copy(32'hFFFF_FFFC, 32'h80, 2);
    start_xfer(32'hFFFF_FFFC, 32'h80, 16'd2);
    start = 1'b1; src = 32'h40; dst = 32'h3C0; len = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("wrap", 7);
    a = 32'h84;
    chk("wrap_mem", mem[a[9:2]], mem[0]);
`ifdef IDS_DMA_FILL_EN
    for (int i = 0; i < 8; i++) exp_q.push_back({32'h300 + 32'(4 * i), 32'hDEADBEEF});
    fill = 1'b1; fill_data = 32'hDEADBEEF;
    @(negedge clk); saw_read = 1'b0;
    start_xfer(32'h0, 32'h300, 16'd8);
    fill = 1'b0;
    wait_done("fill", 9);
    chk("fill_noread", saw_read, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ids_dma_ctrl.md
# ids_dma_ctrl

DMA transfer controller that sequences word-copy operations over the shared DMEM SRAM port. It is the DMA-side master of the DMEM bus: it raises a request, waits for grant from the priority arbiter (the core always wins), and alternates single-word reads and writes until a programmed length is moved. It is configured by a start pulse with source, destination and length, and reports busy/done status.

## Interface
Parameters:
- LEN_W, 16, width of the word-count field; maximum transfer is 2^LEN_W-1 words.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_src_addr  in  32  source byte address; word aligned.
- i_dst_addr  in  32  destination byte address; word aligned.
- i_len  in  LEN_W  number of 32-bit words to copy.
- i_abort  in  1  abort the current transfer.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse on normal completion.
- o_remaining  out  LEN_W  words still to copy.
- o_req  out  1  bus request to the arbiter.
- i_gnt  in  1  bus grant from the arbiter.
- o_addr  out  32  DMEM address.
- o_read  out  1  DMEM read strobe.
- o_write  out  1  DMEM write strobe.
- o_size  out  4  byte mask; constant 4'b1111.
- o_din  out  32  DMEM write data.
- i_dout  in  32  DMEM read data; valid one cycle after a granted read.

## Operation
- States: IDLE, RD, RD_DATA, WR, DONE.
- IDLE: o_req/o_read/o_write = 0. If i_start, load src, dst and remaining registers. Go to DONE if i_len == 0, otherwise go to RD.
- RD: o_req = 1, o_read = 1, o_addr = src. If i_gnt, go to RD_DATA. Otherwise hold RD with outputs unchanged.
- RD_DATA: o_req = 0, strobes 0. Capture i_dout into the data buffer, then go to WR. The capture is unconditional because the SRAM output is valid this cycle regardless of grant.
- WR: o_req = 1, o_write = 1, o_addr = dst, o_din = buffer. If i_gnt:
  - src += 4 and dst += 4, modulo 2^32 (wrap-around is silent).
  - remaining -= 1.
  - If the new remaining is 0, go to DONE; otherwise go to RD.
  - If i_gnt is low, hold WR.
- DONE: o_done = 1 for exactly this cycle, then go to IDLE.
- Abort: i_abort in RD, RD_DATA or WR forces IDLE next cycle. No o_done pulse. If a WR is granted in the same cycle as the abort, that write counts and remaining decrements. i_abort is ignored in IDLE and DONE.
- i_start outside IDLE is ignored; there is no queuing.
- o_remaining equals the remaining register in all states. It keeps its final value after an abort and is 0 after a normal completion.
- Reset values: state IDLE; o_busy, o_done, o_req, o_read, o_write = 0; o_addr, o_din, o_remaining, and the src/dst/buffer registers = 0; o_size = 4'b1111.

## Timing
- Continuous grant: 3 cycles per word (RD, RD_DATA, WR).
- i_start at cycle T gives RD at T+1, DONE (o_done high) at T+1+3N, and IDLE at T+2+3N.
- len = 0: DONE at T+1.
- Each cycle with i_gnt low in RD or WR adds exactly one cycle. Strobes and address stay stable while waiting.
- o_req never drops in RD or WR until a grant is seen. It is low in RD_DATA, which lets the core take the bus between words.
- All outputs are registered or decoded from the state register only. There is no combinational path from i_gnt to any output.

## Configuration
- IDS_DMA_FILL_EN defined:
  - Adds ports i_fill (in, 1) and i_fill_data (in, 32), both sampled with i_start.
  - When i_fill = 1, the transfer skips RD/RD_DATA. It loops in WR writing the latched i_fill_data, so each word takes 1 cycle under continuous grant.
  - src is not incremented in fill mode.
- IDS_DMA_FILL_EN undefined: these ports do not exist and every transfer is a copy.

## Test plan
- Copy, continuous grant: src 0x100, dst 0x200, len 4, i_gnt = 1.
  - Required: dst words equal src words.
  - Required: o_done at T+13, o_remaining = 0.
- Grant stall: i_gnt low for 5 cycles during RD of word 2.
  - Required: o_addr and o_read stay stable through the stall.
  - Required: o_done is delayed by exactly 5 cycles.
- len = 0: i_start gives o_done at T+1 with no o_req assertion.
- Abort in WR with i_gnt = 1, len 3, on word 2.
  - Required: the write occurs and o_remaining = 1.
  - Required: IDLE next cycle, no o_done.
- Async reset mid-transfer (i_rst_n low in RD_DATA): all outputs go to reset values immediately. A new i_start then runs normally.
- Fill mode, IDS_DMA_FILL_EN defined: i_fill = 1, data 0xDEADBEEF, dst 0x300, len 8.
  - Required: 8 writes of 0xDEADBEEF to 0x300–0x31C.
  - Required: o_done at T+9, no o_read asserted.
